// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Covers the FSM encoding, error codes, header layout and the image-size check.
package program_loader_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CSUM = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE,
      ST_ERROR
   } state_t;

   // Word count header, sent most-significant byte first.
   typedef struct packed {
      logic [BYTE_W-1:0] hi;
      logic [BYTE_W-1:0] lo;
   } hdr_t;

   function automatic logic image_fits(input hdr_t n, input logic [31:0] capacity);
      return 32'(n) <= capacity;
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes little-endian into a 32-bit word with a running XOR checksum.
// word_ready rises combinationally on the cycle the 4th byte is shifted in; no backpressure of its own.
module word_assembler
   import program_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic [BYTE_W-1:0] csum,
   output logic              word_ready
);

   logic [1:0] byte_idx;

   // Bytes enter at the top and move down, so the first byte ends in bits 7:0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         word     <= '0;
         csum     <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         csum     <= '0;
         byte_idx <= '0;
      end else if (shift) begin
         word     <= {byte_in, word[WORD_W-1:BYTE_W]};
         csum     <= csum ^ byte_in;
         byte_idx <= byte_idx + 2'd1;
      end
   end

   assign word_ready = shift && (byte_idx == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checked byte image into instruction memory and holds the CPU until it verifies.
// One cycle from a word's 4th byte to imem_we; in_ready depends on state only and drops during the write cycle.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        err_code
);

   localparam logic [31:0] CAPACITY = 32'((1 << ADDR_W) - BASE_ADDR);

   state_t            state, state_nx;
   logic [BYTE_W-1:0] hdr_hi;
   hdr_t              hdr_n;
   logic [15:0]       remaining;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        err;
   logic              xfer;
   logic              load_go;
   logic              asm_shift;
   logic              word_ready;
   logic [BYTE_W-1:0] csum;
   logic [WORD_W-1:0] word;

   assign xfer      = in_valid && in_ready;
   assign hdr_n     = '{hi: hdr_hi, lo: in_data};
   assign asm_shift = xfer && (state == ST_DATA);

   word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (load_go),
      .shift      (asm_shift),
      .byte_in    (in_data),
      .word       (word),
      .csum       (csum),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      load_go   = 1'b0;
      in_ready  = 1'b0;
      imem_we   = 1'b0;
      cpu_hold  = 1'b1;
      load_done = 1'b0;
      load_err  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_start) begin
               state_nx = ST_HDR0;
               load_go  = 1'b1;
            end
         end
         ST_HDR0: begin
            in_ready = 1'b1;
            if (xfer) state_nx = ST_HDR1;
         end
         ST_HDR1: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (!image_fits(hdr_n, CAPACITY)) state_nx = ST_ERROR;
               else if (hdr_n == '0)             state_nx = ST_CSUM;
               else                              state_nx = ST_DATA;
            end
         end
         ST_DATA: begin
            in_ready = 1'b1;
            if (word_ready) state_nx = ST_WRITE;
         end
         ST_WRITE: begin
            imem_we  = 1'b1;
            state_nx = (remaining == 16'd1) ? ST_CSUM : ST_DATA;
         end
         ST_CSUM: begin
            in_ready = 1'b1;
            if (xfer) state_nx = (in_data == csum) ? ST_DONE : ST_ERROR;
         end
         ST_DONE: begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
            if (load_start) begin
               state_nx = ST_HDR0;
               load_go  = 1'b1;
            end
         end
         ST_ERROR: begin
            load_err = 1'b1;
            if (load_start) begin
               state_nx = ST_HDR0;
               load_go  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hdr_hi    <= '0;
         remaining <= '0;
         addr      <= ADDR_W'(BASE_ADDR);
         err       <= ERR_NONE;
      end else begin
         if (load_go) begin
            hdr_hi    <= '0;
            remaining <= '0;
            addr      <= ADDR_W'(BASE_ADDR);
            err       <= ERR_NONE;
         end
         if (state == ST_HDR0 && xfer) hdr_hi <= in_data;
         if (state == ST_HDR1 && xfer) begin
            remaining <= 16'(hdr_n);
            if (!image_fits(hdr_n, CAPACITY)) err <= ERR_LEN;
         end
         // Hold the address on the last word so a full-depth image never wraps.
         if (state == ST_WRITE) begin
            remaining <= remaining - 16'd1;
            if (remaining != 16'd1) addr <= addr + 1'b1;
         end
         if (state == ST_CSUM && xfer && in_data != csum) err <= ERR_CSUM;
      end
   end

   assign imem_addr  = addr;
   assign imem_wdata = word;
   assign err_code   = err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard checked by an independent monitor.
module tb_program_loader;

   localparam int ADDR_W = 2;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int                cyc;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              load_start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [1:0]        err_code;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] words[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Every write strobe must match the next expected write, including its cycle.
   always @(negedge clk) begin
      if (reset === 1'b1 && imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
            chk("wr_data", imem_wdata, mon_e.data);
            chk("wr_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   // Called just after a falling edge; returns just after the falling edge following the transfer.
   task automatic send_byte(input logic [7:0] b, input bit gaps, input bit push,
                            input logic [ADDR_W-1:0] a, input logic [31:0] w);
      int budget;
      if (gaps) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      budget   = 0;
      while (in_ready !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout: byte %h, in_ready %b after %0d cycles, expected 1", b, in_ready, budget);
      end else if (push) begin
         exp_q.push_back('{a, w, cyc + 1});
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_load(input logic [15:0] n, input logic [7:0] cs, input bit gaps, input bit poke);
      logic [31:0] w;
      send_byte(n[15:8], gaps, 1'b0, '0, '0);
      send_byte(n[7:0], gaps, 1'b0, '0, '0);
      for (int i = 0; i < int'(n); i++) begin
         w = words[i];
         for (int j = 0; j < 4; j++) begin
            send_byte(w[8*j +: 8], gaps, j == 3, ADDR_W'(i), w);
            if (poke && i == 1 && j == 1) pulse_start();
         end
      end
      send_byte(cs, gaps, 1'b0, '0, '0);
   endtask

   initial begin
      reset      = 1'b0;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      reset = 1'b1;

      // A byte offered while idle must not be consumed.
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (3) @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      in_valid = 1'b0;

      // Two-word image; XOR of the eight payload bytes is 0x73.
      pulse_start();
      chk("t1_hold_loading", cpu_hold, 1);
      words = '{32'h20220013, 32'h20430001};
      run_load(16'h0002, 8'h73, 1'b0, 1'b0);
      chk("t1_load_done", load_done, 1);
      chk("t1_cpu_hold", cpu_hold, 0);
      chk("t1_err_code", err_code, 0);
      chk("t1_in_ready", in_ready, 0);
      chk("t1_writes_seen", exp_q.size(), 0);

      // Same image, wrong checksum: both words still written.
      pulse_start();
      chk("t2_hold_reasserted", cpu_hold, 1);
      chk("t2_done_cleared", load_done, 0);
      run_load(16'h0002, 8'h70, 1'b0, 1'b0);
      chk("t2_load_err", load_err, 1);
      chk("t2_err_code", err_code, 2);
      chk("t2_cpu_hold", cpu_hold, 1);
      chk("t2_writes_seen", exp_q.size(), 0);

      // Five words into a four-word memory.
      pulse_start();
      chk("t3_err_cleared", load_err, 0);
      chk("t3_code_cleared", err_code, 0);
      send_byte(8'h00, 1'b0, 1'b0, '0, '0);
      send_byte(8'h05, 1'b0, 1'b0, '0, '0);
      chk("t3_load_err", load_err, 1);
      chk("t3_err_code", err_code, 1);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_cpu_hold", cpu_hold, 1);

      // Empty image.
      pulse_start();
      run_load(16'h0000, 8'h00, 1'b0, 1'b0);
      chk("t4_load_done", load_done, 1);
      chk("t4_cpu_hold", cpu_hold, 0);

      // Full-depth image with a stray load_start mid-word; checksum 0x08.
      pulse_start();
      words = '{32'h04030201, 32'h08070605, 32'hDDCCBBAA, 32'h00FF00FF};
      run_load(16'h0004, 8'h08, 1'b0, 1'b1);
      chk("t5_load_done", load_done, 1);
      chk("t5_last_addr", imem_addr, 3);
      chk("t5_writes_seen", exp_q.size(), 0);

      // Reset mid-word, with load_start in the same cycle.
      pulse_start();
      send_byte(8'h00, 1'b0, 1'b0, '0, '0);
      send_byte(8'h02, 1'b0, 1'b0, '0, '0);
      send_byte(8'h11, 1'b0, 1'b0, '0, '0);
      send_byte(8'h22, 1'b0, 1'b0, '0, '0);
      reset      = 1'b0;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      chk("t6_in_ready", in_ready, 0);
      chk("t6_cpu_hold", cpu_hold, 1);
      chk("t6_load_done", load_done, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_idle_in_ready", in_ready, 0);
      chk("t6_idle_cpu_hold", cpu_hold, 1);

      // Three words with random valid gaps; checksum 0x39.
      pulse_start();
      words = '{32'h12345678, 32'hCAFEBABE, 32'h00000001};
      run_load(16'h0003, 8'h39, 1'b1, 1'b0);
      chk("t7_load_done", load_done, 1);
      chk("t7_cpu_hold", cpu_hold, 0);
      repeat (3) @(negedge clk);
      chk("t7_writes_seen", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
